// File: rtl/mips_alu_pkg.sv
// Shared opcode encodings and FSM states for the sequential MIPS ALU.
// The legacy 2-bit ALU codes (AND/OR/ADD/SUB) sit in the low bits of the 4-bit opcode.
package mips_alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mips_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock, WIDTH steps.
// Operands are captured on i_start; o_done flags the final product for a single cycle.
module mips_alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   w_sum;

    // The multiplier lives in the low half and is shifted out as the product shifts in.
    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign o_done    = r_busy & (r_count == CNT_W'(WIDTH));
    assign o_product = {r_hi, r_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_count <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_count <= '0;
            r_mcand <= i_multiplicand;
            r_hi    <= '0;
            r_lo    <= i_multiplier;
        end else if (r_busy) begin
            if (o_done) begin
                r_busy <= 1'b0;
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
                r_count      <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_alu_seq.sv
// Handshaked EX-stage ALU with registered result and Zero/Overflow/Illegal flags.
// Define MIPS_ALU_MUL_EN to build in the iterative multiplier; otherwise MUL is illegal.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_InValid,
    output logic             o_InReady,
    input  logic [WIDTH-1:0] i_Operand1,
    input  logic [WIDTH-1:0] i_Operand2,
    input  logic [3:0]       i_ALUControl,
    output logic             o_OutValid,
    input  logic             i_OutReady,
    output logic [WIDTH-1:0] o_ALUResult,
    output logic [WIDTH-1:0] o_ALUResultHi,
    output logic             o_Zero,
    output logic             o_Overflow,
    output logic             o_Illegal
);

    state_t             r_state;
    logic               r_outValid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_resultHi;
    logic               r_zero;
    logic               r_overflow;
    logic               r_illegal;

    logic               w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_result;
    logic               w_overflow;
    logic               w_illegal;

    assign o_InReady = (r_state == IDLE) | ((r_state == DONE) & i_OutReady);
    assign w_accept  = i_InValid & o_InReady;
    assign w_shamt   = i_Operand2[SHAMT_W-1:0];
    assign w_sum     = i_Operand1 + i_Operand2;
    assign w_diff    = i_Operand1 - i_Operand2;

`ifdef MIPS_ALU_MUL_EN
    logic               w_isMul;
    logic               w_mulDone;
    logic [2*WIDTH-1:0] w_product;

    assign w_isMul = (i_ALUControl == OP_MUL);

    mips_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_accept & w_isMul),
        .i_multiplicand (i_Operand1),
        .i_multiplier   (i_Operand2),
        .o_done         (w_mulDone),
        .o_product      (w_product)
    );
`endif

    // Single-cycle datapath; MUL and unknown opcodes fall through to a zero result.
    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        w_illegal  = 1'b0;
        case (i_ALUControl)
            OP_AND: w_result = i_Operand1 & i_Operand2;
            OP_OR:  w_result = i_Operand1 | i_Operand2;
            OP_ADD: begin
                w_result   = w_sum;
                w_overflow = (i_Operand1[WIDTH-1] == i_Operand2[WIDTH-1]) &
                             (w_sum[WIDTH-1] != i_Operand1[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = (i_Operand1[WIDTH-1] != i_Operand2[WIDTH-1]) &
                             (w_diff[WIDTH-1] != i_Operand1[WIDTH-1]);
            end
            OP_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(i_Operand1) < $signed(i_Operand2))};
            OP_NOR: w_result = ~(i_Operand1 | i_Operand2);
            OP_SLL: w_result = i_Operand1 << w_shamt;
            OP_SRL: w_result = i_Operand1 >> w_shamt;
            OP_SRA: w_result = $unsigned($signed(i_Operand1) >>> w_shamt);
`ifdef MIPS_ALU_MUL_EN
            OP_MUL: w_result = '0;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_resultHi <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
`ifdef MIPS_ALU_MUL_EN
                        if (w_isMul) begin
                            r_state    <= BUSY;
                            r_outValid <= 1'b0;
                        end else
`endif
                        begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                            r_result   <= w_result;
                            r_resultHi <= '0;
                            r_zero     <= (w_result == '0);
                            r_overflow <= w_overflow;
                            r_illegal  <= w_illegal;
                        end
                    end else if ((r_state == DONE) && i_OutReady) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                    end
                end
`ifdef MIPS_ALU_MUL_EN
                BUSY: begin
                    if (w_mulDone) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                        r_result   <= w_product[WIDTH-1:0];
                        r_resultHi <= w_product[2*WIDTH-1:WIDTH];
                        r_zero     <= (w_product[WIDTH-1:0] == '0);
                        r_overflow <= 1'b0;
                        r_illegal  <= 1'b0;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_OutValid    = r_outValid;
    assign o_ALUResult   = r_result;
    assign o_ALUResultHi = r_resultHi;
    assign o_Zero        = r_zero;
    assign o_Overflow    = r_overflow;
    assign o_Illegal     = r_illegal;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Self-checking bench for mips_alu_seq (WIDTH=32): directed vector table, hand-written
// stall/multiply/reset sequences, and randomized ops against an arithmetic reference model.
module tb_mips_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [3:0]   aluControl;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] aluResult;
    logic [W-1:0] aluResultHi;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int nPass  = 0;
    int nTotal = 0;

`ifdef MIPS_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    mips_alu_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_InValid     (inValid),
        .o_InReady     (inReady),
        .i_Operand1    (operand1),
        .i_Operand2    (operand2),
        .i_ALUControl  (aluControl),
        .o_OutValid    (outValid),
        .i_OutReady    (outReady),
        .o_ALUResult   (aluResult),
        .o_ALUResultHi (aluResultHi),
        .o_Zero        (zero),
        .o_Overflow    (overflow),
        .o_Illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expLo;
        logic [W-1:0] expHi;
        logic         expZero;
        logic         expOvf;
        logic         expIll;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nTotal++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Reference model built from plain signed/unsigned arithmetic on wide integers.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic ovf, output logic ill);
        longint sa, sb, s;
        longint unsigned p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        lo = '0; hi = '0; ovf = 1'b0; ill = 1'b0;
        case (op)
            4'd0: lo = a & b;
            4'd1: lo = a | b;
            4'd2: begin s = sa + sb; lo = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3: begin s = sa - sb; lo = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd4: lo = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: lo = ~(a | b);
            4'd6: begin p = longint'(a) << sh; lo = p[31:0]; end
            4'd7: lo = a >> sh;
            4'd8: begin s = sa >>> sh; lo = s[31:0]; end
            4'd9: begin
                if (MUL_EN) begin
                    p  = longint'(a) * longint'(b);
                    lo = p[31:0];
                    hi = p[63:32];
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
    endtask

    // Drive one operation on a falling edge; leaves the bench one falling edge later.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        inValid    = 1'b1;
        aluControl = op;
        operand1   = a;
        operand2   = b;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // Full transaction with latency measurement and model comparison.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eLo, eHi;
        logic eOvf, eIll;
        int cycles, expCycles;
        model(op, a, b, eLo, eHi, eOvf, eIll);
        expCycles = (MUL_EN && op == 4'd9) ? W + 1 : 1;
        applyStimulus(op, a, b);
        cycles = 1;
        while (!outValid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, 64'(cycles), 64'(expCycles));
        checkOutput({tag, " result"}, 64'(aluResult), 64'(eLo));
        checkOutput({tag, " resultHi"}, 64'(aluResultHi), 64'(eHi));
        checkOutput({tag, " zero"}, 64'(zero), 64'(eLo == '0));
        checkOutput({tag, " overflow"}, 64'(overflow), 64'(eOvf));
        checkOutput({tag, " illegal"}, 64'(illegal), 64'(eIll));
    endtask

    initial begin
        logic [W-1:0] heldLo;
        int cycles;

        vecs[0]  = '{4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'd3, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'd0, 32'h000000F0, 32'h0000000F, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd8, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd6, 32'h00000001, 32'd33,       32'h00000002, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'hF, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4'd5, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd7, 32'h80000000, 32'd4,        32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'd1, 32'hA0A00000, 32'h00000505, 32'hA0A00505, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};

        rst_n      = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b0;
        operand1   = '0;
        operand2   = '0;
        aluControl = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset outValid", 64'(outValid), 64'd0);
        checkOutput("reset result", 64'(aluResult), 64'd0);
        checkOutput("reset resultHi", 64'(aluResultHi), 64'd0);
        checkOutput("reset flags", 64'({zero, overflow, illegal}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset inReady", 64'(inReady), 64'd1);

        // Back-to-back directed vectors with the consumer always ready.
        outReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d outValid", i), 64'(outValid), 64'd1);
            checkOutput($sformatf("vec%0d inReady", i), 64'(inReady), 64'd1);
            checkOutput($sformatf("vec%0d result", i), 64'(aluResult), 64'(vecs[i].expLo));
            checkOutput($sformatf("vec%0d resultHi", i), 64'(aluResultHi), 64'(vecs[i].expHi));
            checkOutput($sformatf("vec%0d zero", i), 64'(zero), 64'(vecs[i].expZero));
            checkOutput($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d illegal", i), 64'(illegal), 64'(vecs[i].expIll));
        end
        @(negedge clk);
        checkOutput("drain outValid", 64'(outValid), 64'd0);

        // Consumer stall: result must hold and new requests must be refused.
        outReady = 1'b0;
        applyStimulus(4'd2, 32'd2, 32'd3);
        heldLo = aluResult;
        checkOutput("stall first result", 64'(heldLo), 64'd5);
        for (int i = 0; i < 5; i++) begin
            inValid    = 1'b1;
            aluControl = 4'd0;
            operand1   = $urandom;
            operand2   = $urandom;
            @(negedge clk);
            checkOutput($sformatf("stall%0d result", i), 64'(aluResult), 64'd5);
            checkOutput($sformatf("stall%0d outValid", i), 64'(outValid), 64'd1);
            checkOutput($sformatf("stall%0d inReady", i), 64'(inReady), 64'd0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("stall release outValid", 64'(outValid), 64'd0);
        checkOutput("stall release inReady", 64'(inReady), 64'd1);

        // Multiply corner: full 64-bit product, or illegal when compiled out.
        if (MUL_EN) begin
            applyStimulus(4'd9, 32'hFFFFFFFF, 32'd2);
            checkOutput("mul busy inReady", 64'(inReady), 64'd0);
            checkOutput("mul busy outValid", 64'(outValid), 64'd0);
            cycles = 1;
            while (!outValid && cycles < 100) begin
                @(negedge clk);
                cycles++;
            end
            checkOutput("mul latency", 64'(cycles), 64'(W + 1));
            checkOutput("mul lo", 64'(aluResult), 64'hFFFFFFFE);
            checkOutput("mul hi", 64'(aluResultHi), 64'h1);
            checkOutput("mul illegal", 64'(illegal), 64'd0);
        end else begin
            applyStimulus(4'd9, 32'hFFFFFFFF, 32'd2);
            checkOutput("mul-off outValid", 64'(outValid), 64'd1);
            checkOutput("mul-off result", 64'(aluResult), 64'd0);
            checkOutput("mul-off zero", 64'(zero), 64'd1);
            checkOutput("mul-off illegal", 64'(illegal), 64'd1);
        end

        // Leave a non-zero result, optionally start a multiply, then reset mid-flight.
        outReady = 1'b0;
        applyStimulus(4'd1, 32'h00000F00, 32'h0000000F);
        outReady = 1'b1;
        if (MUL_EN) begin
            applyStimulus(4'd9, 32'd3, 32'd5);
            repeat (9) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("async reset outValid", 64'(outValid), 64'd0);
        checkOutput("async reset result", 64'(aluResult), 64'd0);
        checkOutput("async reset resultHi", 64'(aluResultHi), 64'd0);
        checkOutput("async reset flags", 64'({zero, overflow, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset release outValid", 64'(outValid), 64'd0);
        runOp("after reset add", 4'd2, 32'd2, 32'd3);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h7FFFFFFF + 32'($urandom_range(0, 2));
            runOp($sformatf("rand%0d op%0d", i, op), op, a, b);
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/mips_alu_seq.md
# mips_alu_seq

Parametrised, handshaked successor to the datapath's combinational 2-bit ALU. Executes logic, arithmetic, compare, shift and (optionally) iterative multiply on WIDTH-bit operands, registering every result with Zero/Overflow flags. Sits in the EX stage; single-cycle ops complete in one clock, while MUL stalls the upstream stage through the ready/valid handshake.

## Interface
- WIDTH, 32: operand/result width (≥4).
- SHAMT_W, $clog2(WIDTH): shift-amount bits taken from Operand2[SHAMT_W-1:0].
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- InValid  input  1  operation presented.
- InReady  output  1  block can accept an operation.
- Operand1  input  WIDTH  first operand / shift source.
- Operand2  input  WIDTH  second operand / shift amount.
- ALUControl  input  4  opcode, see Operation.
- OutValid  output  1  result registers valid.
- OutReady  input  1  consumer takes result.
- ALUResult  output  WIDTH  result (product low half for MUL).
- ALUResultHi  output  WIDTH  product high half for MUL, 0 otherwise.
- Zero  output  1  ALUResult == 0, for every opcode.
- Overflow  output  1  signed overflow, ADD/SUB only, else 0.
- Illegal  output  1  opcode unrecognised (or MUL when compiled out).

## Operation
- Opcodes: AND 0000, OR 0001, ADD 0010, SUB 0011 (legacy codes preserved in low 2 bits), SLT 0100 (signed, result 0/1), NOR 0101, SLL 0110, SRL 0111, SRA 1000, MUL 1001 (unsigned), others illegal.
- Accept = InValid & InReady. Operands and opcode captured on accept; later input changes ignored.
- FSM: IDLE, BUSY, DONE.
  - IDLE: accept of non-MUL op -> compute, load result regs, go DONE. Accept of MUL -> go BUSY, counter = 0.
  - BUSY: one shift-add step per cycle; after WIDTH steps load {ALUResultHi, ALUResult}, go DONE.
  - DONE: OutValid = 1. If OutReady: accept of new op allowed same cycle (back-to-back), else go IDLE. Without OutReady, all outputs hold.
- InReady = (state==IDLE) | (state==DONE & OutReady).
- Illegal opcode: ALUResult = 0, ALUResultHi = 0, Zero = 1, Illegal = 1, completes as single-cycle op.
- Widths: ADD/SUB wrap modulo 2^WIDTH; Overflow = sign(A)==sign(B') & sign(R)!=sign(A), B' = ~B for SUB. Shifts use only Operand2[SHAMT_W-1:0]. MUL product is full 2*WIDTH bits.
- Zero is always registered with the result — never a latch, never stale.

## Timing
- Reset (async, rst_n=0): state IDLE, OutValid 0, ALUResult 0, ALUResultHi 0, Zero 0, Overflow 0, Illegal 0, counter 0; InReady 1 one cycle after deassertion (combinational from state).
- Reset mid-MUL: partial product discarded, no OutValid.
- Latency accept -> OutValid: 1 cycle for non-MUL, WIDTH+1 cycles for MUL.
- Throughput: one non-MUL op per cycle when OutReady held high.
- OutReady while OutValid=0 has no effect.

## Configuration
- MIPS_ALU_MUL_EN defined: MUL opcode and iterative multiplier present; BUSY state reachable.
- Undefined: multiplier and BUSY logic removed; MUL treated as an illegal opcode (1-cycle, Illegal=1, result 0).

## Structure
- Package mips_alu_pkg: 4-bit opcode localparams (OP_AND … OP_MUL), FSM state enum (IDLE/BUSY/DONE).
- Sub-module mips_alu_mul_iter: WIDTH-step shift-add unsigned multiplier with start/done, instantiated only under MIPS_ALU_MUL_EN.
- Top holds FSM, single-cycle datapath, output registers and flags.

## Test plan
- Reset then ADD 0x7FFFFFFF+1, OutReady=1 -> next cycle OutValid, ALUResult 0x80000000, Overflow 1, Zero 0.
- SUB 5-5 then AND 0xF0&0x0F back-to-back -> Zero 1 both cycles, one result per cycle, InReady stays 1.
- SLT -1,1 -> 1; SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLL 1 by 33 (shamt 1) -> 2.
- MUL 0xFFFFFFFF*2 -> OutValid after 33 cycles, ALUResultHi 1, ALUResult 0xFFFFFFFE; InReady 0 during BUSY (macro undefined: Illegal 1, result 0, 1 cycle).
- OutReady held 0 for 5 cycles after result -> outputs stable, InReady 0; opcode 1111 -> Illegal 1, Zero 1.
- Assert rst_n low at MUL cycle 10 -> all outputs 0 immediately; after release, ADD 2+3 -> 5.
